ntt_stage_controller: RTL
=========================

// Module: ntt_stage_controller
// PURPOSE
//  Sequences all butterfly stages of one forward NTT on a bank of 2^LOG_CORE_COUNT ntt_core instances.
//  All cores share this block's outputs in lock-step.
//  Drives stage index, twiddle mode, RAM read sweep, delayed write-back and ping-pong bank select.
//  Offers a start/busy/done handshake to the top-level host/DMA.
// PARAMETERS
//  LOG_N          12  log2 of transform length; number of stages = LOG_N (max 15)
//  LOG_CORE_COUNT 5   log2 of core count; must match the cores' LOG_CORE_COUNT
//  PIPE_LATENCY   6   cycles from read_address presented to butterfly result valid at RAM write port (>=1)
//  WORDS          = 2^(LOG_N-LOG_CORE_COUNT-2), derived localparam: RAM words per core RAM (<=512)
// PORTS
//  clk                 in   1   clock, all logic on rising edge
//  rst                 in   1   synchronous reset, active-high
//  start               in   1   request one full NTT; sampled only in IDLE
//  busy                out  1   high while a transform is in progress
//  done                out  1   one-cycle pulse when all stages have been written back
//  log_m               out  4   current stage index
//  i                   out  10  intra-stage group index for mode 1
//  mode                out  2   twiddle addressing mode for the cores
//  read_address        out  9   RAM read address, shared by upper and lower RAMs
//  read_select         out  1   ping-pong bank being read
//  write_select        out  1   ping-pong bank being written; always ~read_select while busy
//  upper_write_enable  out  1   write strobe, upper RAM
//  lower_write_enable  out  1   write strobe, lower RAM
//  upper_write_address out  9   write address, upper RAM
//  lower_write_address out  9   write address, lower RAM
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (busy, done, log_m, i, mode, addresses, enables, read_select=0, write_select=0).
//  Reset mid-transform: abort immediately; next cycle all outputs at reset values; no done pulse.
//  FSM states:
//   IDLE:  start=1 -> RUN, log_m=0, k=0. start while not IDLE is ignored (no queueing).
//   RUN:   per stage, STAGE_LEN = WORDS+PIPE_LATENCY cycles, local counter k=0..STAGE_LEN-1.
//          k<WORDS: read_address=k. k>=WORDS: read_address holds WORDS-1.
//          At k=STAGE_LEN-1: if log_m==LOG_N-1 -> DONE, else log_m+1, k=0, toggle read_select.
//   DONE:  one cycle: done=1, busy=0 -> IDLE. read_select returns to 0 on entering IDLE.
//  busy: high from the cycle after start is sampled for exactly LOG_N*STAGE_LEN cycles.
//  Write-back:
//   Write-enable pipe is PIPE_LATENCY deep. upper/lower_write_enable(t) = (k(t-PIPE_LATENCY) < WORDS).
//   Write addresses = read_address delayed PIPE_LATENCY cycles. Both RAMs are always written together.
//   The pipe is cleared on stage change, so no write crosses a stage boundary.
//   The last write of a stage lands at k=STAGE_LEN-1.
//  write_select = ~read_select while busy, 0 otherwise.
//  Stage 0 reads bank 0 and writes bank 1. The final result lands in bank (LOG_N odd ? 1 : 0).
//  Mode (registered with log_m):
//   log_m <  LOG_CORE_COUNT -> mode 0
//   log_m == LOG_CORE_COUNT -> mode 1
//   log_m >  LOG_CORE_COUNT -> mode 2
//  i: in mode 1, i = {1'b0, read_address}; otherwise 0.
//  Width rules: counters sized for WORDS+PIPE_LATENCY; all address outputs zero-extended to 9 bits.
//  All outputs are registered; the first valid read_address appears on the cycle busy rises.
// TESTING  (LOG_N=8, LOG_CORE_COUNT=2, PIPE_LATENCY=4 -> WORDS=16, STAGE_LEN=20)
//  1 Reset, then start pulse -> busy high exactly 160 cycles; done pulse on cycle 161; busy=0 with done.
//  2 Stage 0 -> read_address 0..15 then held at 15 for 4 cycles.
//    write enables high on k=4..19 with write_address 0..15.
//    read_select=0, write_select=1.
//  3 Stage transitions -> log_m steps 0..7.
//    mode=0 for log_m 0-1, mode=1 for log_m=2 (i tracks read_address), mode=2 for log_m 3-7.
//    read_select toggles on every stage boundary.
//  4 start re-asserted at cycle 50 -> ignored; sequence unchanged; exactly one done.
//  5 rst asserted at cycle 70 -> next cycle all outputs 0, state IDLE, no done.
//    A new start then produces a full 160-cycle run.
//  6 start asserted in the same cycle as done -> ignored; start one cycle later -> new run, busy rises next cycle.

Source files
------------

// File: rtl/ntt_stage_controller_if.sv
// Control bundle between the NTT stage sequencer, the host handshake and the shared core/RAM controls.
// master = sequencer side, slave = host/core side.
interface ntt_stage_controller_if;
   logic       start;
   logic       busy;
   logic       done;
   logic [3:0] log_m;
   logic [9:0] i;
   logic [1:0] mode;
   logic [8:0] read_address;
   logic       read_select;
   logic       write_select;
   logic       upper_write_enable;
   logic       lower_write_enable;
   logic [8:0] upper_write_address;
   logic [8:0] lower_write_address;

   modport master (
      input  start,
      output busy, done, log_m, i, mode, read_address, read_select, write_select,
             upper_write_enable, lower_write_enable, upper_write_address, lower_write_address
   );

   modport slave (
      output start,
      input  busy, done, log_m, i, mode, read_address, read_select, write_select,
             upper_write_enable, lower_write_enable, upper_write_address, lower_write_address
   );
endinterface

// File: rtl/ntt_stage_controller.sv
// Sequences every butterfly stage of one forward NTT for a lock-step bank of cores:
// read sweep, delayed write-back, ping-pong bank select, twiddle mode and start/busy/done.
module ntt_stage_controller #(
   parameter int unsigned LOG_N          = 12,
   parameter int unsigned LOG_CORE_COUNT = 5,
   parameter int unsigned PIPE_LATENCY   = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   ntt_stage_controller_if.master ctrl
);

   localparam int unsigned WORDS     = 2 ** (LOG_N - LOG_CORE_COUNT - 2);
   localparam int unsigned STAGE_LEN = WORDS + PIPE_LATENCY;
   localparam int unsigned KW        = $clog2(STAGE_LEN);

   localparam logic [KW-1:0] K_LAST    = KW'(STAGE_LEN - 1);
   localparam logic [KW-1:0] K_WORDS   = KW'(WORDS);
   localparam logic [8:0]    RA_LAST   = 9'(WORDS - 1);
   localparam logic [3:0]    LOGM_LAST = 4'(LOG_N - 1);
   localparam logic [3:0]    LOGM_M1   = 4'(LOG_CORE_COUNT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [3:0]      log_m_q, log_m_d;
   logic            rsel_q, rsel_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [8:0]      ra_q, ra_d;
   logic [1:0]      mode_q, mode_d;
   logic [9:0]      i_q, i_d;
   logic            wsel_q, wsel_d;
   logic            stage_end;
   logic            wr_valid;
   logic            pipe_clear;

   logic [PIPE_LATENCY-1:0] we_pipe_q;
   logic [8:0]              wa_pipe_q [PIPE_LATENCY];

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      log_m_d   = log_m_q;
      rsel_d    = rsel_q;
      stage_end = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (ctrl.start) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (k_q == K_LAST) begin
               stage_end = 1'b1;
               k_d       = '0;
               if (log_m_q == LOGM_LAST) begin
                  state_d = S_DONE;
               end else begin
                  log_m_d = log_m_q + 4'd1;
                  rsel_d  = ~rsel_q;
               end
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d != S_RUN) begin
         k_d = '0;
      end
      if (state_d == S_IDLE) begin
         log_m_d = '0;
         rsel_d  = 1'b0;
      end

      // Output registers are loaded from next-state values so they line up with k in the same cycle.
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);

      ra_d = '0;
      if (busy_d) begin
         ra_d = (k_d < K_WORDS) ? 9'(k_d) : RA_LAST;
      end

      mode_d = 2'd0;
      if (busy_d) begin
         if (log_m_d < LOGM_M1) begin
            mode_d = 2'd0;
         end else if (log_m_d == LOGM_M1) begin
            mode_d = 2'd1;
         end else begin
            mode_d = 2'd2;
         end
      end

      i_d    = (mode_d == 2'd1) ? {1'b0, ra_d} : '0;
      wsel_d = busy_d & ~rsel_d;

      // A read issued this cycle lands PIPE_LATENCY cycles later; flushing at the stage edge keeps writes in-stage.
      wr_valid   = busy_q && (k_q < K_WORDS);
      pipe_clear = stage_end || !busy_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         log_m_q <= '0;
         rsel_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ra_q    <= '0;
         mode_q  <= '0;
         i_q     <= '0;
         wsel_q  <= 1'b0;
         we_pipe_q <= '0;
         for (int unsigned j = 0; j < PIPE_LATENCY; j++) begin
            wa_pipe_q[j] <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         log_m_q <= log_m_d;
         rsel_q  <= rsel_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ra_q    <= ra_d;
         mode_q  <= mode_d;
         i_q     <= i_d;
         wsel_q  <= wsel_d;
         if (pipe_clear) begin
            we_pipe_q <= '0;
            for (int unsigned j = 0; j < PIPE_LATENCY; j++) begin
               wa_pipe_q[j] <= '0;
            end
         end else begin
            we_pipe_q[0] <= wr_valid;
            wa_pipe_q[0] <= ra_q;
            for (int unsigned j = 1; j < PIPE_LATENCY; j++) begin
               we_pipe_q[j] <= we_pipe_q[j-1];
               wa_pipe_q[j] <= wa_pipe_q[j-1];
            end
         end
      end
   end

   assign ctrl.busy                = busy_q;
   assign ctrl.done                = done_q;
   assign ctrl.log_m               = log_m_q;
   assign ctrl.i                   = i_q;
   assign ctrl.mode                = mode_q;
   assign ctrl.read_address        = ra_q;
   assign ctrl.read_select         = rsel_q;
   assign ctrl.write_select        = wsel_q;
   assign ctrl.upper_write_enable  = we_pipe_q[PIPE_LATENCY-1];
   assign ctrl.lower_write_enable  = we_pipe_q[PIPE_LATENCY-1];
   assign ctrl.upper_write_address = wa_pipe_q[PIPE_LATENCY-1];
   assign ctrl.lower_write_address = wa_pipe_q[PIPE_LATENCY-1];

endmodule
